// File: rtl/module_ula_74181_nibble_seq_if.sv
// Request/response bus of the nibble-serial 74181 sequencer.
// Optional: when ULA_SEQ_ZERO_FLAG_EN is defined, the response side
// carries an extra rsp_zero flag.
`timescale 1ns/1ps
interface module_ula_74181_nibble_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic           req_valid;
    logic           req_ready;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic [3:0]     req_s;
    logic           req_m;
    logic           req_c_in;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_f;
    logic           rsp_c_out;
    logic           rsp_a_eq_b;
`ifdef ULA_SEQ_ZERO_FLAG_EN
    logic           rsp_zero;
`endif

    // Sequencer side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_a, req_b, req_s, req_m, req_c_in, rsp_ready,
        output req_ready, rsp_valid, rsp_f, rsp_c_out, rsp_a_eq_b
`ifdef ULA_SEQ_ZERO_FLAG_EN
        , output rsp_zero
`endif
    );

    // Requester side: issues operations, consumes results.
    modport master (
        output req_valid, req_a, req_b, req_s, req_m, req_c_in, rsp_ready,
        input  req_ready, rsp_valid, rsp_f, rsp_c_out, rsp_a_eq_b
`ifdef ULA_SEQ_ZERO_FLAG_EN
        , input rsp_zero
`endif
    );
endinterface

// File: rtl/module_ula_74181_nibble_seq.sv
// Nibble-serial sequencer for a single external 4-bit 74181 slice.
// A wide operation is fed through the slice LSB nibble first, one nibble
// per clock, with the slice carry registered between nibbles so the
// result matches NIBBLES slices cascaded c_out -> c_in.
// Optional: define ULA_SEQ_ZERO_FLAG_EN to add the rsp_zero result flag.
`timescale 1ns/1ps
module module_ula_74181_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    module_ula_74181_nibble_seq_if.slave      bus,
    output logic [3:0]                        alu_a,
    output logic [3:0]                        alu_b,
    output logic [3:0]                        alu_s,
    output logic                              alu_m,
    output logic                              alu_c_in,
    input  logic [3:0]                        alu_f,
    input  logic                              alu_a_eq_b,
    input  logic                              alu_c_out
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [3:0]         s_q, s_d;
    logic               m_q, m_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               eq_q, eq_d;
    logic [W-1:0]       rsp_f_q, rsp_f_d;
    logic               rsp_c_out_q, rsp_c_out_d;
    logic               rsp_a_eq_b_q, rsp_a_eq_b_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_zero_q, rsp_zero_d;

    logic               last_nib_s;
    logic               req_ready_s;
    logic [IDX_W+1:0]   nib_base_s;

    assign last_nib_s = (idx_q == LAST_IDX);
    assign nib_base_s = {idx_q, 2'b00};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: IDLE -> RUN on accept, RUN -> DONE after the last nibble, DONE -> IDLE on response handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_nib_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Slice drive and request-ready: the slice only sees operands while RUN, zeros otherwise.
    always_comb begin
        req_ready_s = 1'b0;
        alu_a       = 4'd0;
        alu_b       = 4'd0;
        alu_s       = 4'd0;
        alu_m       = 1'b0;
        alu_c_in    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_s = 1'b1;
            end
            ST_RUN: begin
                alu_a    = a_q[nib_base_s +: 4];
                alu_b    = b_q[nib_base_s +: 4];
                alu_s    = s_q;
                alu_m    = m_q;
                alu_c_in = carry_q;
            end
            ST_DONE: begin
                req_ready_s = 1'b0;
            end
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    // Datapath next values: operand latch, per-nibble result/carry/equality accumulation, response flags.
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        s_d          = s_q;
        m_d          = m_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        eq_d         = eq_q;
        rsp_f_d      = rsp_f_q;
        rsp_c_out_d  = rsp_c_out_q;
        rsp_a_eq_b_d = rsp_a_eq_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    s_d     = bus.req_s;
                    m_d     = bus.req_m;
                    idx_d   = '0;
                    // Logic mode never propagates a carry into any nibble.
                    carry_d = bus.req_m ? 1'b0 : bus.req_c_in;
                    eq_d    = 1'b1;
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_RUN: begin
                rsp_f_d[nib_base_s +: 4] = alu_f;
                carry_d = m_q ? 1'b0 : alu_c_out;
                eq_d    = eq_q & alu_a_eq_b;
                if (last_nib_s) begin
                    rsp_c_out_d  = m_q ? 1'b0 : alu_c_out;
                    rsp_a_eq_b_d = eq_q & alu_a_eq_b;
                    rsp_valid_d  = 1'b1;
                    rsp_zero_d   = ~|rsp_f_d;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            s_q          <= 4'd0;
            m_q          <= 1'b0;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            eq_q         <= 1'b0;
            rsp_f_q      <= '0;
            rsp_c_out_q  <= 1'b0;
            rsp_a_eq_b_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            s_q          <= s_d;
            m_q          <= m_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            eq_q         <= eq_d;
            rsp_f_q      <= rsp_f_d;
            rsp_c_out_q  <= rsp_c_out_d;
            rsp_a_eq_b_q <= rsp_a_eq_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_f      = rsp_f_q;
    assign bus.rsp_c_out  = rsp_c_out_q;
    assign bus.rsp_a_eq_b = rsp_a_eq_b_q;
`ifdef ULA_SEQ_ZERO_FLAG_EN
    assign bus.rsp_zero   = rsp_zero_q;
`else
    // Zero flag is tracked but not exported in this build.
    logic unused_zero_s;
    assign unused_zero_s = rsp_zero_q;
`endif

endmodule

// File: tb/tb_module_ula_74181_nibble_seq.sv
// Self-checking bench for module_ula_74181_nibble_seq (NIBBLES=4) with a
// behavioural 74181 slice attached and a response scoreboard.
`timescale 1ns/1ps
module tb_module_ula_74181_nibble_seq;
    localparam int NIB = 4;

    typedef struct {
        logic [15:0] f;
        logic        c;
        logic        eq;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_a, alu_b, alu_s, alu_f;
    logic        alu_m, alu_c_in, alu_c_out, alu_a_eq_b;

    int          n_vec;
    int          n_err;
    exp_t        sb[$];
    logic        cin_hist [0:7];

    module_ula_74181_nibble_seq_if #(.NIBBLES(NIB)) bus ();

    module_ula_74181_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_m      (alu_m),
        .alu_c_in   (alu_c_in),
        .alu_f      (alu_f),
        .alu_a_eq_b (alu_a_eq_b),
        .alu_c_out  (alu_c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 74181 slice, active-high data, carry treated as active-high (+cin).
    // Logic mode reports carry 1 so that an unmasked carry is visible.
    function automatic logic [5:0] slice181(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] s, input logic m, input logic cin);
        logic [3:0] x, y, f;
        logic [4:0] sum;
        logic       co;
        x = 4'd0; y = 4'd0; f = 4'd0; co = 1'b1; sum = 5'd0;
        if (m) begin
            case (s)
                4'h0: f = ~a;        4'h1: f = ~(a | b);  4'h2: f = ~a & b;    4'h3: f = 4'h0;
                4'h4: f = ~(a & b);  4'h5: f = ~b;        4'h6: f = a ^ b;     4'h7: f = a & ~b;
                4'h8: f = ~a | b;    4'h9: f = ~(a ^ b);  4'hA: f = b;         4'hB: f = a & b;
                4'hC: f = 4'hF;      4'hD: f = a | ~b;    4'hE: f = a | b;     default: f = a;
            endcase
        end else begin
            case (s)
                4'h0: begin x = a;       y = 4'h0;   end
                4'h1: begin x = a | b;   y = 4'h0;   end
                4'h2: begin x = a | ~b;  y = 4'h0;   end
                4'h3: begin x = 4'h0;    y = 4'hF;   end
                4'h4: begin x = a;       y = a & ~b; end
                4'h5: begin x = a | b;   y = a & ~b; end
                4'h6: begin x = a;       y = ~b;     end
                4'h7: begin x = a & ~b;  y = 4'hF;   end
                4'h8: begin x = a;       y = a & b;  end
                4'h9: begin x = a;       y = b;      end
                4'hA: begin x = a | ~b;  y = a & b;  end
                4'hB: begin x = a & b;   y = 4'hF;   end
                4'hC: begin x = a;       y = a;      end
                4'hD: begin x = a | b;   y = a;      end
                4'hE: begin x = a | ~b;  y = a;      end
                default: begin x = a;    y = 4'hF;   end
            endcase
            sum = {1'b0, x} + {1'b0, y} + {4'd0, cin};
            f   = sum[3:0];
            co  = sum[4];
        end
        return {(f == 4'hF), co, f};
    endfunction

    // Reference: NIB slices cascaded c_out -> c_in; returns {eq, c_out, f}.
    function automatic logic [17:0] wide_ref(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] s, input logic m, input logic cin);
        logic [15:0] f;
        logic        c, eq;
        logic [5:0]  r;
        f = 16'd0; c = m ? 1'b0 : cin; eq = 1'b1;
        for (int i = 0; i < NIB; i++) begin
            r = slice181(a[4*i +: 4], b[4*i +: 4], s, m, c);
            f[4*i +: 4] = r[3:0];
            c  = m ? 1'b0 : r[4];
            eq = eq & r[5];
        end
        return {eq, c, f};
    endfunction

    assign {alu_a_eq_b, alu_c_out, alu_f} = slice181(alu_a, alu_b, alu_s, alu_m, alu_c_in);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_req(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                             input logic m, input logic cin, input bit push,
                             input logic [15:0] ef, input logic ec);
        logic [17:0] r;
        exp_t e;
        r = wide_ref(a, b, s, m, cin);
        @(posedge clk); #1;
        bus.req_a = a; bus.req_b = b; bus.req_s = s; bus.req_m = m; bus.req_c_in = cin;
        bus.req_valid = 1'b1;
        if (push) begin
            e.f = ef; e.c = ec; e.eq = r[17];
            sb.push_back(e);
        end
    endtask

    // Wait until the request is taken, then drop valid and scramble the operands.
    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 50);
        if (!bus.req_ready) check_val("acc_timeout", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_a = ~bus.req_a;
        bus.req_b = bus.req_b ^ 16'hA5C3;
        bus.req_c_in = ~bus.req_c_in;
    endtask

    // Called just after the accept edge: counts negedges until rsp_valid, logging alu_c_in.
    task automatic wait_rsp(output int edges);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            if (n < 8) cin_hist[n] = alu_c_in;
            n++;
        end while (!bus.rsp_valid && n < 40);
        if (!bus.rsp_valid) check_val("rsp_timeout", {31'd0, bus.rsp_valid}, 32'd1);
        edges = n - 1;
    endtask

    // Scoreboard: compare every handshaken response with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check_val("unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("rsp_f", {16'd0, bus.rsp_f}, {16'd0, e.f});
                check_val("rsp_c_out", {31'd0, bus.rsp_c_out}, {31'd0, e.c});
                check_val("rsp_a_eq_b", {31'd0, bus.rsp_a_eq_b}, {31'd0, e.eq});
`ifdef ULA_SEQ_ZERO_FLAG_EN
                check_val("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, (e.f == 16'd0)});
`endif
            end
        end
    end

    initial begin
        int lat;
        int seen;
        logic [17:0] r;
        logic [15:0] ra, rb;
        logic [3:0]  rs;
        logic        rm, rc;
        n_vec = 0; n_err = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_a = 16'd0; bus.req_b = 16'd0;
        bus.req_s = 4'd0; bus.req_m = 1'b0; bus.req_c_in = 1'b0; bus.rsp_ready = 1'b1;
        #2;
        check_val("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_val("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_val("rst_rsp_flags", {16'd0, bus.rsp_f, 14'd0, bus.rsp_c_out, bus.rsp_a_eq_b}, 32'd0);
        check_val("rst_alu", {18'd0, alu_a, alu_b, alu_s, alu_m, alu_c_in}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Add 0x00FF + 0x0001.
        drive_req(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);
        wait_accept();
        wait_rsp(lat);
        check_val("lat_add", lat, 32'd4);

        // Add with overflow; carry ripples into nibbles 1..3.
        drive_req(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        wait_accept();
        wait_rsp(lat);
        check_val("ovf_cin_seq", {28'd0, cin_hist[0], cin_hist[1], cin_hist[2], cin_hist[3]}, 32'b0111);

        // A plus Cin.
        drive_req(16'h0FFF, 16'h1234, 4'b0000, 1'b0, 1'b1, 1'b1, 16'h1000, 1'b0);
        wait_accept();
        wait_rsp(lat);
        check_val("lat_aplus", lat, 32'd4);

        // Logic XOR with cin=1: no carry ever reaches the slice.
        drive_req(16'h5A5A, 16'h00FF, 4'b0110, 1'b1, 1'b1, 1'b1, 16'h5AA5, 1'b0);
        wait_accept();
        wait_rsp(lat);
        check_val("xor_cin_seq", {28'd0, cin_hist[0], cin_hist[1], cin_hist[2], cin_hist[3]}, 32'd0);

        // Backpressure with a pending request.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        drive_req(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        wait_accept();
        wait_rsp(lat);
        drive_req(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check_val("bp_f_hold", {16'd0, bus.rsp_f}, 32'h5555);
            check_val("bp_c_hold", {31'd0, bus.rsp_c_out}, 32'd0);
            check_val("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_val("bp_hs_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        check_val("bp_idle_ready", {31'd0, bus.req_ready}, 32'd1);
        check_val("bp_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_rsp(lat);
        check_val("bp_pending_lat", lat, 32'd4);

        // Reset while RUN is at nibble 2 of 0x1234 + 0x1111.
        drive_req(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        wait_accept();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_val("mid_alu_a", {28'd0, alu_a}, 32'd2);
        check_val("mid_rsp_f", {16'd0, bus.rsp_f}, 32'h0045);
        #1 rst = 1'b1;
        #1;
        check_val("mrst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_val("mrst_ready", {31'd0, bus.req_ready}, 32'd1);
        check_val("mrst_alu", {18'd0, alu_a, alu_b, alu_s, alu_m, alu_c_in}, 32'd0);
        check_val("mrst_rsp_f", {16'd0, bus.rsp_f}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check_val("post_rst_quiet", seen, 32'd0);

        // Random operations against the cascaded reference.
        for (int k = 0; k < 24; k++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rs = 4'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            if (k < 4) rb = ra;
            r = wide_ref(ra, rb, rs, rm, rc);
            drive_req(ra, rb, rs, rm, rc, 1'b1, r[15:0], r[16]);
            wait_accept();
            wait_rsp(lat);
        end

        @(negedge clk);
        @(negedge clk);
        check_val("sb_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/module_ula_74181_nibble_seq.md
Name: module_ula_74181_nibble_seq

Overview:
- Sequencing initiator for one 4-bit `module_ula_74181` slice.
- Accepts a wide operation (A, B, S, M, Cin) over a valid/ready request channel.
- Drives the external ALU slice one nibble per clock, LSB nibble first, with a registered carry between nibbles.
- Returns the assembled wide result over a valid/ready response channel.
- Result must equal NIBBLES `module_ula_74181` instances cascaded c_out→c_in.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand/result width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request ready; high only in IDLE
- req_a  in  W  operand A
- req_b  in  W  operand B
- req_s  in  4  74181 function select
- req_m  in  1  mode: 0 arithmetic, 1 logic
- req_c_in  in  1  carry into nibble 0
- alu_a  out  4  current A nibble to ALU slice
- alu_b  out  4  current B nibble to ALU slice
- alu_s  out  4  latched select
- alu_m  out  1  latched mode
- alu_c_in  out  1  carry into current nibble
- alu_f  in  4  ALU result nibble (combinational from alu_* outputs)
- alu_a_eq_b  in  1  ALU A=B flag for current nibble
- alu_c_out  in  1  ALU carry out for current nibble
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_f  out  W  assembled result
- rsp_c_out  out  1  carry out of last nibble (0 in logic mode)
- rsp_a_eq_b  out  1  AND of all per-nibble alu_a_eq_b

Behaviour:
- One clock (clk). Reset rst is asynchronous, active-high.
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_f=0, rsp_c_out=0, rsp_a_eq_b=0.
  - alu_a=0, alu_b=0, alu_s=0, alu_m=0, alu_c_in=0, nibble index=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1; alu_* outputs driven 0.
  - On req_valid&&req_ready at an edge: latch A, B, S, M, Cin.
  - At that edge: idx←0; carry←(M ? 0 : req_c_in); eq←1; go to RUN.
- RUN (one cycle per nibble idx):
  - Drive alu_a=A[4*idx+3:4*idx], alu_b=B[4*idx+3:4*idx], alu_s=S, alu_m=M, alu_c_in=carry.
  - At the edge: rsp_f nibble idx←alu_f; carry←(M ? 0 : alu_c_out); eq←eq & alu_a_eq_b.
  - If idx==NIBBLES-1: rsp_c_out←(M ? 0 : alu_c_out); rsp_a_eq_b←final eq; rsp_valid←1; go to DONE. Otherwise idx←idx+1.
- DONE:
  - rsp_* held stable while rsp_ready=0; alu_* outputs 0.
  - On rsp_valid&&rsp_ready: rsp_valid←0, go to IDLE. rsp_f and flags keep their values until the next op overwrites them.
- Latency: request accepted at edge T; rsp_valid rises after edge T+NIBBLES.
- Throughput: at most one op per NIBBLES+2 cycles. No request accept in the same cycle as the response handshake.
- Req_* changes after accept are ignored.
- req_valid while busy is held off by req_ready=0 and is not lost.
- Carry chaining: arithmetic mode passes raw alu_c_out to the next nibble, exactly as the cascaded-slice wiring does. No inversion and no lookahead.
- Logic mode: alu_c_in=0 for every nibble; rsp_c_out=0.
- NIBBLES=1: RUN lasts one cycle; all rules still apply.
- Reset mid-operation (RUN or DONE): all outputs return immediately to reset values and the operation is discarded. No response is produced after reset release.

Optional Feature:
- Macro: ULA_SEQ_ZERO_FLAG_EN.
- Defined: adds output port rsp_zero (out, 1).
  - Registered with rsp_f; equals 1 iff the assembled W-bit result is all zeros.
  - Reset value 0; held stable in DONE like the other rsp_* outputs.
- Not defined: port rsp_zero and its logic are absent; all other behaviour is identical.

Test Plan:
- Add, A=0x00FF, B=0x0001, s=1001, m=0, cin=0 → rsp_f=0x0100, rsp_c_out=0; rsp_valid rises exactly 4 edges after accept.
- Add with overflow, A=0xFFFF, B=0x0001, s=1001, m=0, cin=0 → rsp_f=0x0000, rsp_c_out=1; alu_c_in observed 0,1,1,1 across nibbles 0..3.
- A plus Cin, A=0x0FFF, B=0x1234, s=0000, m=0, cin=1 → rsp_f=0x1000, rsp_c_out=0.
- Logic XOR, A=0x5A5A, B=0x00FF, s=0110, m=1, cin=1 → rsp_f=0x5AA5, rsp_c_out=0; alu_c_in=0 on every nibble.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid.
  - rsp_f, rsp_c_out and rsp_valid stay stable; req_ready=0 and a pending req_valid is not accepted.
  - Raise rsp_ready → DONE→IDLE, and the pending request is accepted on the following edge.
- Reset during RUN at idx=2 → same cycle: rsp_valid=0, req_ready=1, alu_*=0, rsp_f=0; no response appears over the following 10 cycles.
